// File: rtl/history_table_spec.sv
// history_table_spec: per-set local branch-history table with speculative shift, repair and flush sweep
module history_table_spec #(
  parameter int WIDTH = 8,
  parameter int S_INDEX = 3,
  parameter int NUM_SETS = 2**S_INDEX,
  parameter bit BYPASS = 0,
  parameter int FW = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [S_INDEX-1:0] rd_index,
  output logic [WIDTH-1:0]   rd_history,
  output logic [FW-1:0]      rd_fill,
  input  logic               upd_valid,
  input  logic [S_INDEX-1:0] upd_index,
  input  logic               upd_bit,
  input  logic               rep_valid,
  input  logic [S_INDEX-1:0] rep_index,
  input  logic [WIDTH-1:0]   rep_history,
  input  logic [FW-1:0]      rep_fill,
  input  logic               flush_req,
  output logic               busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;
  localparam logic [S_INDEX:0] NS = (S_INDEX+1)'(NUM_SETS);
  localparam logic [FW-1:0] FMAX = FW'(WIDTH);
  logic [WIDTH-1:0] hist [NUM_SETS];
  logic [FW-1:0] fill [NUM_SETS];
  logic [0:0] state;
  logic [S_INDEX-1:0] ptr;
  logic idle, rep_ok, upd_live, rd_ok, last;
  logic [WIDTH-1:0] upd_h;
  logic [FW-1:0] upd_f, rep_f;
  assign busy = state == SWEEP;
  always_comb begin
    idle = state == IDLE;
    last = ptr == S_INDEX'(NUM_SETS-1);
    rep_ok = idle && rep_valid && {1'b0, rep_index} < NS;
    upd_live = idle && upd_valid && {1'b0, upd_index} < NS && !(rep_ok && rep_index == upd_index);
    upd_h = {hist[upd_index][WIDTH-2:0], upd_bit};
    upd_f = fill[upd_index] == FMAX ? FMAX : fill[upd_index] + 1'b1;
    rep_f = rep_fill > FMAX ? FMAX : rep_fill;
    rd_ok = {1'b0, rd_index} < NS;
    rd_history = rd_ok ? hist[rd_index] : '0;
    rd_fill = rd_ok ? fill[rd_index] : '0;
    // forwarded view is exactly what the next edge will store, reset and sweep included
    if (BYPASS) begin
      rd_history = reset || (!idle && rd_index == ptr) ? '0 :
                   rep_ok && rep_index == rd_index ? rep_history :
                   upd_live && upd_index == rd_index ? upd_h : rd_history;
      rd_fill = reset || (!idle && rd_index == ptr) ? '0 :
                rep_ok && rep_index == rd_index ? rep_f :
                upd_live && upd_index == rd_index ? upd_f : rd_fill;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
      state <= IDLE;
      ptr <= '0;
    end else if (state == SWEEP) begin
      hist[ptr] <= '0;
      fill[ptr] <= '0;
      ptr <= last ? '0 : ptr + 1'b1;
      state <= last ? IDLE : SWEEP;
    end else begin
      if (upd_live) begin
        hist[upd_index] <= upd_h;
        fill[upd_index] <= upd_f;
      end
      if (rep_ok) begin
        hist[rep_index] <= rep_history;
        fill[rep_index] <= rep_f;
      end
      if (flush_req) begin
        state <= SWEEP;
        ptr <= '0;
      end
    end
endmodule

// File: tb/tb_history_table_spec.sv
// tb_history_table_spec: directed plan plus random traffic against a behavioural table model
module tb_history_table_spec;
  logic clk = 0, reset = 1;
  logic [2:0] rd_index = 0, upd_index = 0, rep_index = 0;
  logic upd_valid = 0, upd_bit = 0, rep_valid = 0, flush_req = 0;
  logic [7:0] rep_history = 0;
  logic [3:0] rep_fill = 0;
  logic [7:0] ha, hb, hc;
  logic [3:0] fa, fb, fc;
  logic ba, bb, bc;
  int nvec = 0, nerr = 0, c;
  bit chk_on = 0;
  int mh[2][8], mf[2][8], mptr[2];
  bit mbusy[2];

  always #5 clk = ~clk;

  history_table_spec #(.WIDTH(8), .S_INDEX(3), .BYPASS(0)) ua (.clk(clk), .reset(reset), .rd_index(rd_index),
    .rd_history(ha), .rd_fill(fa), .upd_valid(upd_valid), .upd_index(upd_index), .upd_bit(upd_bit),
    .rep_valid(rep_valid), .rep_index(rep_index), .rep_history(rep_history), .rep_fill(rep_fill),
    .flush_req(flush_req), .busy(ba));
  history_table_spec #(.WIDTH(8), .S_INDEX(3), .BYPASS(1)) ub (.clk(clk), .reset(reset), .rd_index(rd_index),
    .rd_history(hb), .rd_fill(fb), .upd_valid(upd_valid), .upd_index(upd_index), .upd_bit(upd_bit),
    .rep_valid(rep_valid), .rep_index(rep_index), .rep_history(rep_history), .rep_fill(rep_fill),
    .flush_req(flush_req), .busy(bb));
  history_table_spec #(.WIDTH(8), .S_INDEX(3), .NUM_SETS(6), .BYPASS(0)) uc (.clk(clk), .reset(reset), .rd_index(rd_index),
    .rd_history(hc), .rd_fill(fc), .upd_valid(upd_valid), .upd_index(upd_index), .upd_bit(upd_bit),
    .rep_valid(rep_valid), .rep_index(rep_index), .rep_history(rep_history), .rep_fill(rep_fill),
    .flush_req(flush_req), .busy(bc));

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // model 0 is the full 8-set table, model 1 the 6-set table
  function automatic int nh(int m, int k);
    int ns = m ? 6 : 8;
    if (reset) return 0;
    if (mbusy[m]) return k == mptr[m] ? 0 : mh[m][k];
    if (k >= ns) return 0;
    if (rep_valid && rep_index == k) return int'(rep_history);
    if (upd_valid && upd_index == k) return ((mh[m][k] << 1) | int'(upd_bit)) & 255;
    return mh[m][k];
  endfunction

  function automatic int nf(int m, int k);
    int ns = m ? 6 : 8;
    if (reset) return 0;
    if (mbusy[m]) return k == mptr[m] ? 0 : mf[m][k];
    if (k >= ns) return 0;
    if (rep_valid && rep_index == k) return rep_fill > 8 ? 8 : int'(rep_fill);
    if (upd_valid && upd_index == k) return mf[m][k] < 8 ? mf[m][k] + 1 : 8;
    return mf[m][k];
  endfunction

  always @(posedge clk)
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 8; k++) begin
        mh[m][k] <= nh(m, k);
        mf[m][k] <= nf(m, k);
      end
      if (reset) begin
        mbusy[m] <= 0;
        mptr[m] <= 0;
      end else if (mbusy[m]) begin
        mbusy[m] <= mptr[m] != (m ? 5 : 7);
        mptr[m] <= mptr[m] == (m ? 5 : 7) ? 0 : mptr[m] + 1;
      end else if (flush_req) begin
        mbusy[m] <= 1;
        mptr[m] <= 0;
      end
    end

  always @(negedge clk)
    if (chk_on) begin
      chk("a_hist", ha, mh[0][rd_index]);
      chk("a_fill", fa, mf[0][rd_index]);
      chk("a_busy", ba, mbusy[0]);
      chk("b_hist", hb, nh(0, rd_index));
      chk("b_fill", fb, nf(0, rd_index));
      chk("b_busy", bb, mbusy[0]);
      chk("c_hist", hc, mh[1][rd_index]);
      chk("c_fill", fc, mf[1][rd_index]);
      chk("c_busy", bc, mbusy[1]);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    upd_valid = 0;
    rep_valid = 0;
    flush_req = 0;
    reset = 0;
  endtask

  task automatic expect_a(int idx, int h, int f);
    rd_index = 3'(idx);
    #2;
    chk("lit_hist", ha, h);
    chk("lit_fill", fa, f);
    tick();
  endtask

  task automatic expect_all_zero();
    for (int i = 0; i < 8; i++) expect_a(i, 0, 0);
  endtask

  initial begin
    logic [9:0] pat;
    pat = 10'b1011001011;
    tick();
    chk_on = 1;
    tick();
    idle_in();
    #2 chk("rst_busy", ba, 0);
    expect_all_zero();
    for (int i = 9; i >= 0; i--) begin
      upd_valid = 1; upd_index = 3; upd_bit = pat[i];
      tick();
    end
    idle_in();
    expect_a(3, 8'hCB, 8);
    expect_a(2, 0, 0);
    upd_valid = 1; upd_index = 2; upd_bit = 1;
    rep_valid = 1; rep_index = 2; rep_history = 8'h5A; rep_fill = 4;
    tick();
    upd_index = 1; rep_index = 5; rep_history = 8'hFF; rep_fill = 8;
    tick();
    idle_in();
    expect_a(2, 8'h5A, 4);
    expect_a(1, 8'h01, 1);
    expect_a(5, 8'hFF, 8);
    upd_valid = 1; upd_index = 4; upd_bit = 1;
    tick();
    tick();
    rd_index = 4;
    #2;
    chk("byp1_same", hb, 8'h07);
    chk("byp0_same", ha, 8'h03);
    tick();
    idle_in();
    #2 chk("byp0_next", ha, 8'h07);
    for (int i = 0; i < 8; i++) begin
      rep_valid = 1; rep_index = 3'(i); rep_history = 8'(i * 17 + 1); rep_fill = 8;
      tick();
    end
    idle_in();
    flush_req = 1;
    tick();
    flush_req = 0;
    c = 0;
    while (ba === 1'b1 && c < 20) begin
      c++;
      upd_valid = c == 2; upd_index = 7; upd_bit = 1;
      if (c <= 8) begin
        rd_index = 3'(c - 1);
        #1 chk("sweep_old", ha, (c - 1) * 17 + 1);
      end
      if (c >= 2) begin
        rd_index = 3'(c - 2);
        #1 chk("sweep_zero", ha, 0);
      end
      tick();
    end
    idle_in();
    chk("busy_len", c, 8);
    expect_all_zero();
    for (int i = 0; i < 8; i++) begin
      upd_valid = 1; upd_index = 3'(i); upd_bit = 1;
      tick();
    end
    idle_in();
    flush_req = 1;
    tick();
    flush_req = 0;
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    #2 chk("abort_busy", ba, 0);
    expect_all_zero();
    upd_valid = 1; upd_index = 6; upd_bit = 1;
    tick();
    idle_in();
    expect_a(6, 1, 1);
    repeat (3000) begin
      reset = $urandom_range(199) == 0;
      flush_req = $urandom_range(39) == 0;
      upd_valid = $urandom_range(1) == 1;
      upd_index = 3'($urandom_range(7));
      upd_bit = $urandom_range(1) == 1;
      rep_valid = $urandom_range(9) < 3;
      rep_index = $urandom_range(3) == 0 ? upd_index : 3'($urandom_range(7));
      rep_history = 8'($urandom);
      rep_fill = 4'($urandom);
      rd_index = 3'($urandom_range(7));
      tick();
    end
    idle_in();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
